// File: rtl/etc_pkg.sv
// rtl/etc_pkg.sv - shared ETC lane constants, FSM encoding and window helper
//
// Purpose: constants and types shared by the vehicle emulator and the ETC
//   receiver, so both sides of the lane agree on sensor placement and on the
//   clock/speed/distance scaling.
// Ports: none (package).
package etc_pkg;

  localparam int WIDTH_SPEED = 14;
  localparam int WIDTH_POS   = 16;
  // clocks * km/h per mm at 50 MHz: 50e6 * 3.6 / 1000
  localparam int MM_DIV      = 180000;
  localparam int D2_MM       = 4800;
  localparam int D3_MM       = 12000;
  localparam int VEH_LEN_MM  = 1440;
  localparam int STOP_MM     = 500;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } etc_state_e;

  // True while the vehicle front lies within the window [lo, lo+len).
  function automatic logic in_window(input int unsigned pos,
                                     input int unsigned lo,
                                     input int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/etc_vehicle_emulator_if.sv
// rtl/etc_vehicle_emulator_if.sv - command and lane-sensor bundle of the vehicle emulator
//
// Purpose: groups the pass command inputs and the emulated lane outputs.
// Signals:
//   start, speed_kmh, has_epass  command side (driven by master)
//   barrier                      barrier open flag, only with ETC_GEN_BARRIER_STOP_EN
//   sensor1..3, valid_Epass      emulated lane sensors (driven by slave)
//   busy, done                   pass status (driven by slave)
// Modports: master = command source, slave = emulator.
interface etc_vehicle_emulator_if #(
  parameter int WIDTH_SPEED = etc_pkg::WIDTH_SPEED
);

  logic                   start;
  logic [WIDTH_SPEED-1:0] speed_kmh;
  logic                   has_epass;
`ifdef ETC_GEN_BARRIER_STOP_EN
  logic                   barrier;
`endif
  logic                   sensor1;
  logic                   sensor2;
  logic                   sensor3;
  logic                   valid_Epass;
  logic                   busy;
  logic                   done;

`ifdef ETC_GEN_BARRIER_STOP_EN
  modport master (output start, speed_kmh, has_epass, barrier,
                  input  sensor1, sensor2, sensor3, valid_Epass, busy, done);
  modport slave  (input  start, speed_kmh, has_epass, barrier,
                  output sensor1, sensor2, sensor3, valid_Epass, busy, done);
`else
  modport master (output start, speed_kmh, has_epass,
                  input  sensor1, sensor2, sensor3, valid_Epass, busy, done);
  modport slave  (input  start, speed_kmh, has_epass,
                  output sensor1, sensor2, sensor3, valid_Epass, busy, done);
`endif

endinterface

// File: rtl/etc_mm_stepper.sv
// rtl/etc_mm_stepper.sv - phase accumulator turning a speed into 1 mm step strobes
//
// Purpose: adds spd every enabled clock; each time the sum crosses MM_DIV
//   one millimetre of travel has elapsed and mm_step is asserted for that
//   cycle. Average step period is MM_DIV/spd clocks without a divider.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   spd           speed in km/h (must stay below MM_DIV)
//   enable        advance the accumulator this cycle
//   clear         zero the accumulator (has priority over enable)
//   mm_step       combinational strobe, high in a cycle that completes 1 mm
module etc_mm_stepper #(
  parameter int WIDTH_SPEED = etc_pkg::WIDTH_SPEED,
  parameter int MM_DIV      = etc_pkg::MM_DIV
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH_SPEED-1:0] spd,
  input  logic                   enable,
  input  logic                   clear,
  output logic                   mm_step
);

  // Residue stays below MM_DIV and spd adds less than MM_DIV, so the
  // sum never overflows this width.
  localparam int ACC_W = WIDTH_SPEED + 18;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  assign sum     = acc + ACC_W'(spd);
  assign mm_step = enable && (sum >= ACC_W'(MM_DIV));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= mm_step ? (sum - ACC_W'(MM_DIV)) : sum;
    end
  end

endmodule

// File: rtl/etc_vehicle_emulator.sv
// rtl/etc_vehicle_emulator.sv - vehicle emulator producing ETC lane sensor timing from a speed
//
// Purpose: on start, latches speed and E-pass presence, then moves a virtual
//   vehicle front through the lane 1 mm at a time and raises each loop sensor
//   while the vehicle covers it. Pulses done when the rear clears sensor3.
// Optional feature: ETC_GEN_BARRIER_STOP_EN adds the barrier input; the
//   vehicle waits STOP_MM before sensor3 until the barrier opens.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset, aborts a pass without done
//   bus      etc_vehicle_emulator_if.slave (command in, sensors/status out)
module etc_vehicle_emulator
  import etc_pkg::*;
#(
  parameter int WIDTH_SPEED = etc_pkg::WIDTH_SPEED,
  parameter int WIDTH_POS   = etc_pkg::WIDTH_POS,
  parameter int MM_DIV      = etc_pkg::MM_DIV,
  parameter int D2_MM       = etc_pkg::D2_MM,
  parameter int D3_MM       = etc_pkg::D3_MM,
  parameter int VEH_LEN_MM  = etc_pkg::VEH_LEN_MM
`ifdef ETC_GEN_BARRIER_STOP_EN
  , parameter int STOP_MM   = etc_pkg::STOP_MM
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  etc_vehicle_emulator_if.slave bus
);

  localparam logic [WIDTH_POS-1:0] END_POS = WIDTH_POS'(D3_MM + VEH_LEN_MM);

  etc_state_e             state, state_next;
  logic [WIDTH_POS-1:0]   pos, pos_next;
  logic [WIDTH_SPEED-1:0] spd;
  logic                   epass, epass_next;
  logic                   accept, finish, stall, step_en, mm_step;
  logic                   busy_next, s1_next, s2_next, s3_next, valid_next;
  logic                   sensor1_q, sensor2_q, sensor3_q, valid_q, busy_q, done_q;

  assign accept  = (state == ST_IDLE) && bus.start && (bus.speed_kmh != '0);

`ifdef ETC_GEN_BARRIER_STOP_EN
  localparam logic [WIDTH_POS-1:0] STOP_POS = WIDTH_POS'(D3_MM - STOP_MM);
  // Only the exact stop point waits; once past it the barrier is irrelevant.
  assign stall = (pos == STOP_POS) && !bus.barrier;
`else
  assign stall = 1'b0;
`endif

  assign step_en = (state == ST_RUN) && !stall;

  etc_mm_stepper #(
    .WIDTH_SPEED (WIDTH_SPEED),
    .MM_DIV      (MM_DIV)
  ) u_stepper (
    .clk     (clk),
    .reset_n (reset_n),
    .spd     (spd),
    .enable  (step_en),
    .clear   (accept),
    .mm_step (mm_step)
  );

  always_comb begin
    pos_next = pos;
    if (accept) begin
      pos_next = '0;
    end else if (mm_step) begin
      pos_next = pos + WIDTH_POS'(1);
    end
  end

  assign finish = (state == ST_RUN) && (pos_next == END_POS);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (finish) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: sensors are decoded from the next position so they change
  // on the same edge as the position they reflect.
  always_comb begin
    busy_next  = (state_next == ST_RUN);
    epass_next = accept ? bus.has_epass : epass;
    s1_next    = busy_next && in_window(32'(pos_next), 0, VEH_LEN_MM);
    s2_next    = busy_next && in_window(32'(pos_next), D2_MM, VEH_LEN_MM);
    s3_next    = busy_next && in_window(32'(pos_next), D3_MM, VEH_LEN_MM);
    valid_next = s2_next && epass_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos       <= '0;
      spd       <= '0;
      epass     <= 1'b0;
      sensor1_q <= 1'b0;
      sensor2_q <= 1'b0;
      sensor3_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pos       <= pos_next;
      epass     <= epass_next;
      if (accept) begin
        spd <= bus.speed_kmh;
      end
      sensor1_q <= s1_next;
      sensor2_q <= s2_next;
      sensor3_q <= s3_next;
      valid_q   <= valid_next;
      busy_q    <= busy_next;
      done_q    <= finish;
    end
  end

  assign bus.sensor1     = sensor1_q;
  assign bus.sensor2     = sensor2_q;
  assign bus.sensor3     = sensor3_q;
  assign bus.valid_Epass = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
